// File: rtl/alu_issue_sched_if.sv
// Bundle between the issue scheduler and its two requesters, the drain controller and the pipeline.
// Handshake: a requester entry transfers on a rising clk edge where reqN_valid && reqN_ready; reqN_ready does not depend on reqN_valid.
interface alu_issue_sched_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic [7:0]       req0_inst;
  logic             req0_ready;
  logic             req1_valid;
  logic [7:0]       req1_inst;
  logic             req1_ready;
  logic             drain_req;
  logic             drained;
  logic [7:0]       issue_inst;
  logic             issue_valid;
  logic             issue_src;
  logic [CNT_W-1:0] issue_cnt0;
  logic [CNT_W-1:0] issue_cnt1;
  logic [1:0]       dbg_state;

  modport master (
    output req0_valid, req0_inst, req1_valid, req1_inst, drain_req,
    input  req0_ready, req1_ready, drained, issue_inst, issue_valid,
           issue_src, issue_cnt0, issue_cnt1, dbg_state
  );

  modport slave (
    input  req0_valid, req0_inst, req1_valid, req1_inst, drain_req,
    output req0_ready, req1_ready, drained, issue_inst, issue_valid,
           issue_src, issue_cnt0, issue_cnt1, dbg_state
  );
endinterface

// File: rtl/alu_issue_sched.sv
// Two-requester round-robin issue scheduler feeding the ID/EX/WB ALU pipeline,
// with a drain/halt FSM that reports when all issued work has committed.
module alu_issue_sched #(
  parameter int FIFO_DEPTH   = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  alu_issue_sched_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CW     = PTR_W + 1;
  localparam int DCNT_W = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [7:0]       mem_q    [2][FIFO_DEPTH];
  logic [7:0]       mem_d    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  logic [1:0]        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        issue_inst_q, issue_inst_d;
  logic              issue_valid_q, issue_valid_d;
  logic              issue_src_q, issue_src_d;
  logic              drained_q, drained_d;

  logic [1:0] req_valid;
  logic [7:0] req_inst [2];
  logic [1:0] ready;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       arb_en;
  logic       pop_any;
  logic       sel;

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_inst[0] = bus.req0_inst;
  assign req_inst[1] = bus.req1_inst;

  // Ready looks only at the stored count, so a same-cycle pop never frees a slot early.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = count_q[i] < CW'(FIFO_DEPTH);
      nonempty[i] = count_q[i] != '0;
      push[i]     = req_valid[i] & ready[i];
    end
  end

  always_comb begin
    arb_en  = (state_q == ST_RUN) && !bus.drain_req;
    pop_any = 1'b0;
    sel     = 1'b0;
    if (arb_en) begin
      if (nonempty[0] && nonempty[1]) begin
        pop_any = 1'b1;
        sel     = ~last_grant_q;
      end else if (nonempty[0]) begin
        pop_any = 1'b1;
        sel     = 1'b0;
      end else if (nonempty[1]) begin
        pop_any = 1'b1;
        sel     = 1'b1;
      end
    end
    pop = {pop_any & sel, pop_any & ~sel};
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = req_inst[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
      count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    issue_inst_d  = pop_any ? mem_q[sel][rd_ptr_q[sel]] : 8'h00;
    issue_valid_d = pop_any;
    issue_src_d   = pop_any & sel;
    last_grant_d  = pop_any ? sel : last_grant_q;
  end

  // DRAIN always runs its full length so the last issued instruction reaches WB.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.drain_req) begin
          state_d = ST_DRAIN;
          dcnt_d  = DCNT_W'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) state_d = ST_HALTED;
        else              dcnt_d  = dcnt_q - DCNT_W'(1);
      end
      ST_HALTED: begin
        if (!bus.drain_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    drained_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
        cnt_q[i]    <= '0;
      end
      state_q       <= ST_RUN;
      dcnt_q        <= '0;
      last_grant_q  <= 1'b1;
      issue_inst_q  <= 8'h00;
      issue_valid_q <= 1'b0;
      issue_src_q   <= 1'b0;
      drained_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      last_grant_q  <= last_grant_d;
      issue_inst_q  <= issue_inst_d;
      issue_valid_q <= issue_valid_d;
      issue_src_q   <= issue_src_d;
      drained_q     <= drained_d;
    end
  end

  // Storage needs no reset: entries are unreachable once the counts are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  assign bus.drained     = drained_q;
  assign bus.issue_inst  = issue_inst_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_src   = issue_src_q;
  assign bus.issue_cnt0  = cnt_q[0];
  assign bus.issue_cnt1  = cnt_q[1];
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: issue stream checked against an expected queue,
// plus reset, latency, back-pressure, drain timing and reset-during-drain checks.
module tb_alu_issue_sched;
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  bit   mon_en = 1'b0;
  bit   seen;
  int   issued_n = 0;
  int   committed_n = 0;
  logic id_v = 1'b0;
  logic ex_v = 1'b0;

  alu_issue_sched_if #(.CNT_W(16)) bus ();

  alu_issue_sched #(
    .FIFO_DEPTH(2),
    .DRAIN_CYCLES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every issued instruction must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.issue_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_issue: observed=%0h expected=none", {bus.issue_src, bus.issue_inst});
        end else begin
          mon_e = exp_q.pop_front();
          check("issue", 32'({bus.issue_src, bus.issue_inst}), 32'(mon_e));
        end
      end else begin
        check("idle", 32'({bus.issue_valid, bus.issue_src, bus.issue_inst}), 32'd0);
      end
    end
  end

  // Pipeline commit model: ID captures the issue register, EX follows, WB writes the register file.
  always @(posedge clk) begin
    if (rst) begin
      id_v <= 1'b0;
      ex_v <= 1'b0;
      issued_n = 0;
      committed_n = 0;
    end else begin
      if (bus.issue_valid === 1'b1) issued_n++;
      if (ex_v) committed_n++;
      id_v <= bus.issue_valid;
      ex_v <= id_v;
    end
  end

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_inst  = 8'h00;
    bus.req1_valid = 1'b0;
    bus.req1_inst  = 8'h00;
    bus.drain_req  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_issue_inst", 32'(bus.issue_inst), 32'h00);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd1);
    check("rst_ready1", 32'(bus.req1_ready), 32'd1);
    check("rst_cnt0", 32'(bus.issue_cnt0), 32'd0);
    check("rst_cnt1", 32'(bus.issue_cnt1), 32'd0);
    check("rst_drained", 32'(bus.drained), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_RUN));
    step();
    rst = 1'b0;
    mon_en = 1'b1;

    // Back-to-back from requester 0, latency of two cycles
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'h46;
    exp_q.push_back({1'b0, 8'h46});
    step();
    bus.req0_inst = 8'h99;
    exp_q.push_back({1'b0, 8'h99});
    @(negedge clk);
    check("lat_early", 32'(bus.issue_valid), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("lat_2cyc", 32'(bus.issue_inst), 32'h46);
    repeat (3) step();
    check("t2_cnt0", 32'(bus.issue_cnt0), 32'd2);
    check("t2_cnt1", 32'(bus.issue_cnt1), 32'd0);

    // Fresh reset so requester 0 wins the first contended grant
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();

    // Both requesters loaded with two entries: strict alternation
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'hA0;
    bus.req1_valid = 1'b1;
    bus.req1_inst  = 8'hB0;
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hB0});
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB1});
    step();
    bus.req0_inst = 8'hA1;
    bus.req1_inst = 8'hB1;
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (5) step();
    check("t3_cnt0", 32'(bus.issue_cnt0), 32'd2);
    check("t3_cnt1", 32'(bus.issue_cnt1), 32'd2);

    // Pushes while halted fill the FIFO, then back-pressure until issue resumes
    bus.drain_req = 1'b1;
    for (int i = 0; i < 20 && bus.drained !== 1'b1; i++) step();
    check("t4_drained", 32'(bus.drained), 32'd1);
    check("t4_state", 32'(bus.dbg_state), 32'(ST_HALTED));
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'h51;
    exp_q.push_back({1'b0, 8'h51});
    step();
    bus.req0_inst = 8'h62;
    exp_q.push_back({1'b0, 8'h62});
    step();
    bus.req0_inst = 8'h73;
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_ready", 32'(bus.req0_ready), 32'd0);
      step();
    end
    check("t4_cnt0_halted", 32'(bus.issue_cnt0), 32'd2);
    bus.drain_req = 1'b0;
    for (int i = 0; i < 20 && bus.req0_ready !== 1'b1; i++) step();
    check("t4_ready_back", 32'(bus.req0_ready), 32'd1);
    check("t4_undrained", 32'(bus.drained), 32'd0);
    exp_q.push_back({1'b0, 8'h73});
    step();
    bus.req0_valid = 1'b0;
    repeat (5) step();
    check("t4_cnt0", 32'(bus.issue_cnt0), 32'd5);

    // Drain timing relative to the last issued instruction
    bus.req1_valid = 1'b1;
    bus.req1_inst  = 8'h41;
    exp_q.push_back({1'b1, 8'h41});
    step();
    bus.req1_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.issue_inst === 8'h41) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_seen", 32'(seen), 32'd1);
    step();
    bus.drain_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_not_yet", 32'(bus.drained), 32'd0);
    end
    @(negedge clk);
    check("t5_drained", 32'(bus.drained), 32'd1);
    check("t5_rf_written", 32'(committed_n), 32'(issued_n));
    check("t5_cnt1", 32'(bus.issue_cnt1), 32'd3);
    bus.drain_req = 1'b0;
    step();
    @(negedge clk);
    check("t5_release", 32'(bus.drained), 32'd0);
    check("t5_run", 32'(bus.dbg_state), 32'(ST_RUN));

    // Reset while draining with both FIFOs holding work
    step();
    bus.drain_req  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_inst  = 8'hE4;
    bus.req1_valid = 1'b1;
    bus.req1_inst  = 8'hF5;
    step();
    check("t6_in_drain", 32'(bus.dbg_state), 32'(ST_DRAIN));
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.drain_req  = 1'b0;
    step();
    @(negedge clk);
    check("t6_state", 32'(bus.dbg_state), 32'(ST_RUN));
    check("t6_ready0", 32'(bus.req0_ready), 32'd1);
    check("t6_ready1", 32'(bus.req1_ready), 32'd1);
    check("t6_drained", 32'(bus.drained), 32'd0);
    check("t6_issue_inst", 32'(bus.issue_inst), 32'h00);
    step();
    rst = 1'b0;
    exp_q.delete();
    repeat (6) step();
    check("t6_cnt0", 32'(bus.issue_cnt0), 32'd0);
    check("t6_cnt1", 32'(bus.issue_cnt1), 32'd0);
    check("t6_no_issue", 32'(bus.issue_valid), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
